// File: rtl/cnn_pkg.sv
// Shared types and default sizing for the CNN layer schedulers.
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_MAC,
    DRAIN,
    CLOSE
  } l2_sched_state_t;

  localparam int L2_N_OUT = 100;
  localparam int L2_N_RD  = 25;
  localparam int L2_TMO   = 15;

endpackage

// File: rtl/wdog_cnt.sv
// Load/increment watchdog. `expired` fires on the increment that brings the
// count to LIMIT, so a completion in that same cycle can still win.
module wdog_cnt #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= '0;
    else if (inc)  cnt <= cnt + 1'b1;
  end

  assign expired = inc && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/l2_sched.sv
// Frame scheduler for layer 2: one window pop + strt per output, counts
// outputs and downstream reads, closes the frame with one tx_done pulse.
module l2_sched
  import cnn_pkg::*;
#(
  parameter int N_OUT = L2_N_OUT,
  parameter int N_RD  = L2_N_RD,
  parameter int TMO   = L2_TMO
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_go,
  input  logic       abort,
  input  logic       l1_win_vld,
  output logic       l1_win_pop,
  output logic       l2_strt,
  input  logic       l2_addr_rd_inc,
  input  logic       l2_rd,
  output logic       l2_tx_done,
  output logic       busy,
  output logic       frame_done,
  output logic [6:0] out_cnt,
  output logic       err_tmo
);

  l2_sched_state_t state, nxt;

  logic [4:0] rd_cnt;
  logic       clr, out_inc, tmo_set, wd_load, wd_inc, wd_exp;

  assign busy   = (state != IDLE);
  assign wd_inc = (state == WAIT_MAC);

  wdog_cnt #(.LIMIT(TMO)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .load    (wd_load),
    .inc     (wd_inc),
    .expired (wd_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Reads overlap computation, so they are counted in every active state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt <= '0;
      rd_cnt  <= '0;
      err_tmo <= 1'b0;
    end else if (clr) begin
      out_cnt <= '0;
      rd_cnt  <= '0;
      err_tmo <= 1'b0;
    end else begin
      if (out_inc) out_cnt <= out_cnt + 7'd1;
      if (tmo_set) err_tmo <= 1'b1;
      if (busy && l2_rd && rd_cnt != 5'(N_RD)) rd_cnt <= rd_cnt + 5'd1;
    end
  end

  always_comb begin
    nxt        = state;
    l1_win_pop = 1'b0;
    l2_strt    = 1'b0;
    l2_tx_done = 1'b0;
    frame_done = 1'b0;
    clr        = 1'b0;
    out_inc    = 1'b0;
    tmo_set    = 1'b0;
    wd_load    = 1'b0;
    case (state)
      IDLE: begin
        if (frame_go) begin
          clr = 1'b1;
          nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (abort) nxt = CLOSE;
        else if (l1_win_vld) begin
          l2_strt    = 1'b1;
          l1_win_pop = 1'b1;
          wd_load    = 1'b1;
          nxt        = WAIT_MAC;
        end
      end
      // Completion is checked before expiry: a late answer still counts.
      WAIT_MAC: begin
        if (abort) nxt = CLOSE;
        else if (l2_addr_rd_inc) begin
          out_inc = 1'b1;
          nxt     = (out_cnt == 7'(N_OUT - 1)) ? DRAIN : ISSUE;
        end else if (wd_exp) begin
          tmo_set = 1'b1;
          nxt     = CLOSE;
        end
      end
      DRAIN: begin
        if (abort || rd_cnt == 5'(N_RD)) nxt = CLOSE;
      end
      // Already closing, so an abort here adds nothing.
      CLOSE: begin
        l2_tx_done = 1'b1;
        frame_done = 1'b1;
        nxt        = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: doc/l2_sched.md
# l2_sched

Frame-level scheduler for the layer-2 convolution engine. It takes one complete input window per output from the layer-1 window buffer and issues one `strt` to layer 2 per output. It counts finished outputs and downstream reads, then closes the frame with a single `tx_done` pulse that rewinds the layer-2 address counters. It sits between the layer-1 window buffer, the layer-2 engine, and the top-level frame controller.

## Interface
Parameters:
- `N_OUT`, 100: layer-2 outputs per frame (written to the layer-2 RAM).
- `N_RD`, 25: downstream reads of the layer-2 RAM per frame.
- `TMO`, 15: maximum cycles from `l2_strt` to `l2_addr_rd_inc` before a timeout error.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous active-high reset.
- `frame_go`, in, 1: pulse that starts a frame. Ignored unless the block is in IDLE.
- `abort`, in, 1: forces the frame to close.
- `l1_win_vld`, in, 1: level. A full 18-element window is available.
- `l1_win_pop`, out, 1: one-cycle pulse that consumes the window.
- `l2_strt`, out, 1: one-cycle start to layer 2.
- `l2_addr_rd_inc`, in, 1: pulse from layer 2 meaning one output has been written.
- `l2_rd`, in, 1: layer-2 RAM read strobe, one per read cycle.
- `l2_tx_done`, out, 1: one-cycle frame close/rewind to layer 2.
- `busy`, out, 1: high in every state except IDLE.
- `frame_done`, out, 1: one-cycle pulse, coincident with `l2_tx_done`.
- `out_cnt`, out, 7: outputs completed in the current frame.
- `err_tmo`, out, 1: sticky timeout flag. Cleared by `rst` or by a `frame_go` that is accepted.

## Operation
- States:
  - IDLE, ISSUE, WAIT_MAC, DRAIN, CLOSE.
- Transitions:
  - IDLE: on `frame_go`, clear `out_cnt`, `rd_cnt` and `err_tmo`, then go to ISSUE.
  - ISSUE: when `l1_win_vld=1`, assert `l2_strt` and `l1_win_pop` combinationally for this cycle, load the watchdog with 0, and go to WAIT_MAC. Otherwise stay in ISSUE.
  - WAIT_MAC: the watchdog increments every cycle.
    - On `l2_addr_rd_inc`, `out_cnt` increments. If the new value equals `N_OUT`, go to DRAIN; otherwise go to ISSUE.
    - If the watchdog reaches `TMO` without `l2_addr_rd_inc`, set `err_tmo` and go to CLOSE.
  - DRAIN: when `rd_cnt==N_RD`, go to CLOSE.
  - CLOSE: assert `l2_tx_done` and `frame_done` for one cycle, then go to IDLE.
- `rd_cnt` (5 bits):
  - Counts `l2_rd` in every state except IDLE. Reads overlap computation.
  - Saturates at `N_RD`.
- Abort and simultaneous events:
  - `abort` in any non-IDLE state goes to CLOSE next cycle. `abort` in IDLE does nothing.
  - `abort` has priority over every other event in the same cycle.
  - In WAIT_MAC, `l2_addr_rd_inc` in the same cycle as the watchdog expiring counts as completion, not timeout.
- `l2_strt` is never asserted in WAIT_MAC. Layer 2 ignores `strt` while busy, and a window popped then would be lost.
- `out_cnt` never exceeds `N_OUT`. An `l2_addr_rd_inc` outside WAIT_MAC is ignored.

## Timing
- Reset values:
  - state IDLE.
  - `l1_win_pop`, `l2_strt`, `l2_tx_done`, `busy`, `frame_done`, `err_tmo` all 0.
  - `out_cnt` 0.
  - Internal `rd_cnt` and watchdog 0.
- Reset mid-frame returns to IDLE immediately and issues no `l2_tx_done`. Layer 2 is reset by the same top-level reset.
- `frame_go` at edge k puts the block in ISSUE in cycle k+1. If `l1_win_vld=1`, `l2_strt` is high in cycle k+1.
- Layer 2 returns `l2_addr_rd_inc` 5 cycles after `l2_strt`. The next `l2_strt` comes one cycle later, so layer 2 is back in IDLE.
- Steady state is one output per 6 cycles. A frame is at least 600 cycles plus DRAIN plus 1 for CLOSE.
- `out_cnt` is registered; it updates on the edge after `l2_addr_rd_inc`.

## Structure
- Shared package `cnn_pkg`:
  - enum `l2_sched_state_t` (IDLE, ISSUE, WAIT_MAC, DRAIN, CLOSE).
  - Defaults for `N_OUT`, `N_RD` and `TMO`.
- One natural sub-module, `wdog_cnt`: load/increment counter with an expiry compare. It is also reusable by the schedulers for other layers.
- State register and counters live in separate `always_ff` blocks. Next-state and output decode are one `always_comb`.

## Test plan
- Nominal frame:
  - Stimulus: `l1_win_vld` held 1; a layer-2 model answers 5 cycles after each `strt`; 25 `l2_rd` pulses spread across the frame.
  - Response: exactly 100 `l2_strt` and 100 `l1_win_pop` pulses 6 cycles apart; `out_cnt`=100; one `l2_tx_done`/`frame_done`.
- Window starvation:
  - Stimulus: `l1_win_vld` dropped for 20 cycles after output 40.
  - Response: state holds in ISSUE with no `l2_strt`, then resumes; `out_cnt` reaches 100.
- Drain:
  - Stimulus: only 20 reads arrive before output 100, then 5 more arrive 30 cycles later.
  - Response: DRAIN holds 30 cycles; CLOSE follows the cycle after the 25th read.
- Timeout:
  - Stimulus: the model withholds `l2_addr_rd_inc` after output 7.
  - Response: `err_tmo`=1 after 15 cycles in WAIT_MAC, `l2_tx_done` next, `out_cnt`=7, back to IDLE.
- Abort:
  - Stimulus: `abort` and `l2_addr_rd_inc` in the same cycle at output 50.
  - Response: CLOSE next cycle, `l2_tx_done` pulse, and `frame_go` during CLOSE ignored.
- Reset:
  - Stimulus: `rst` mid-WAIT_MAC.
  - Response: all outputs 0 and IDLE with no clock edge; a new `frame_go` runs a full 100-output frame.
